// File: rtl/dtm_dmi_master_pkg.sv
// Types shared between the DTM scan block and the DMI transaction engine.
package dmi_pkg;

    typedef enum logic [1:0] {
        DmiNop   = 2'd0,
        DmiRead  = 2'd1,
        DmiWrite = 2'd2,
        DmiRsvd  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        StatNoError  = 2'd0,
        StatReserved = 2'd1,
        StatFailed   = 2'd2,
        StatBusy     = 2'd3
    } dmistat_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StRsp   = 2'd2,
        StDrain = 2'd3
    } dmi_fsm_e;

    function automatic logic is_access(input logic [1:0] op);
        return (op == DmiRead) || (op == DmiWrite);
    endfunction

    // A response op of 1 is not a legal DM status; treat it as a failure.
    function automatic dmistat_e rsp_to_stat(input logic [1:0] op);
        return (op == 2'd1) ? StatFailed : dmistat_e'(op);
    endfunction

endpackage

// File: rtl/dtm_dmi_master_if.sv
// DMI request/response bus between the DTM transaction engine and the Debug Module.
interface dtm_dmi_master_if #(
    parameter int unsigned ABITS = 7
);
    logic             req_valid;
    logic             req_ready;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_op;

    modport master (
        output req_valid, req_addr, req_data, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_op
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_op
    );
endinterface

// File: rtl/dtm_dmi_master_timeout_cnt.sv
// Clear/enable counter that flags the TIMEOUT-th enabled cycle since the last clear.
module dmi_timeout_cnt #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned CW_RAW  = $clog2(TIMEOUT + 1);
    localparam int unsigned CW      = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int unsigned LAST_I  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LAST  = CW'(LAST_I);
    localparam bit          ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] r_cnt;

    assign o_expire = ENABLED && i_en && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/dtm_dmi_master.sv
// DMI transaction engine: turns DMI Update-DR events into single DM requests, tracks dmistat.
module dtm_dmi_master
    import dmi_pkg::*;
#(
    parameter int unsigned ABITS   = 7,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_update,
    input  logic [1:0]       scan_op,
    input  logic [ABITS-1:0] scan_addr,
    input  logic [31:0]      scan_data,
    input  logic             scan_capture,
    input  logic             dmireset,
    input  logic             dmihardreset,
    output logic [ABITS-1:0] cap_addr,
    output logic [31:0]      cap_data,
    output logic [1:0]       cap_op,
    output logic [1:0]       dmistat,
    output logic             busy,
    dtm_dmi_master_if.master dmi
);
    dmi_fsm_e         r_state, w_state_nxt;
    dmistat_e         r_dmistat, w_stat_nxt;
    logic [ABITS-1:0] r_req_addr, r_cap_addr;
    logic [31:0]      r_req_data, r_cap_data;
    logic [1:0]       r_req_op;
    logic             r_req_valid, r_rsp_ready, r_busy;
    logic             w_launch, w_rsp_take, w_to_err, w_busy_err;
    logic             w_cnt_clr, w_cnt_en, w_expire;

    dmi_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_rsp_take  = 1'b0;
        w_to_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (scan_update && is_access(scan_op) && (r_dmistat == StatNoError)) begin
                    w_state_nxt = StReq;
                    w_launch    = 1'b1;
                end
            end
            StReq: begin
                if (dmihardreset) begin
                    w_state_nxt = StIdle;
                end else if (r_req_valid && dmi.req_ready) begin
                    w_state_nxt = StRsp;
                end
            end
            StRsp: begin
                // A response arriving alongside a hard reset is already consumed; no drain needed.
                if (dmi.rsp_valid) begin
                    w_state_nxt = StIdle;
                    w_rsp_take  = 1'b1;
                end else if (dmihardreset) begin
                    w_state_nxt = StDrain;
                end else if (w_expire) begin
                    w_state_nxt = StDrain;
                    w_to_err    = 1'b1;
                end
            end
            StDrain: begin
                if (dmi.rsp_valid || w_expire) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_cnt_clr  = (w_state_nxt != r_state);
    assign w_cnt_en   = (r_state == StRsp) || (r_state == StDrain);
    assign w_busy_err = (r_state != StIdle) &&
                        ((scan_update && is_access(scan_op)) || scan_capture);

    // Later assignments win: clears beat response/timeout errors, which beat busy errors.
    always_comb begin
        w_stat_nxt = r_dmistat;
        if (r_dmistat == StatNoError) begin
            if (w_busy_err) w_stat_nxt = StatBusy;
            if (w_rsp_take && (dmi.rsp_op != 2'd0)) w_stat_nxt = rsp_to_stat(dmi.rsp_op);
            if (w_to_err) w_stat_nxt = StatFailed;
        end
        if (dmireset || dmihardreset) w_stat_nxt = StatNoError;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_dmistat   <= StatNoError;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_op    <= '0;
            r_cap_addr  <= '0;
            r_cap_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dmistat   <= w_stat_nxt;
            r_req_valid <= (w_state_nxt == StReq);
            r_rsp_ready <= (w_state_nxt == StRsp) || (w_state_nxt == StDrain);
            r_busy      <= (w_state_nxt != StIdle);
            if (w_launch) begin
                r_req_addr <= scan_addr;
                r_req_data <= scan_data;
                r_req_op   <= scan_op;
                r_cap_addr <= scan_addr;
            end
            if (w_rsp_take) begin
                r_cap_data <= dmi.rsp_data;
            end
        end
    end

    assign dmi.req_valid = r_req_valid;
    assign dmi.req_addr  = r_req_addr;
    assign dmi.req_data  = r_req_data;
    assign dmi.req_op    = r_req_op;
    assign dmi.rsp_ready = r_rsp_ready;

    assign cap_addr = r_cap_addr;
    assign cap_data = r_cap_data;
    assign dmistat  = r_dmistat;
    assign busy     = r_busy;
    assign cap_op   = r_busy ? StatBusy : r_dmistat;
endmodule

// File: tb/tb_dtm_dmi_master.sv
// Directed bench for dtm_dmi_master; the bench plays the DM and scoreboards cap_addr/cap_data.
module tb_dtm_dmi_master;
    localparam int unsigned ABITS   = 7;
    localparam int unsigned TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             scan_update, scan_capture, dmireset, dmihardreset;
    logic [1:0]       scan_op;
    logic [ABITS-1:0] scan_addr;
    logic [31:0]      scan_data;
    logic [ABITS-1:0] cap_addr;
    logic [31:0]      cap_data;
    logic [1:0]       cap_op, dmistat;
    logic             busy;

    dtm_dmi_master_if #(.ABITS(ABITS)) bus ();

    dtm_dmi_master #(
        .ABITS   (ABITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_update  (scan_update),
        .scan_op      (scan_op),
        .scan_addr    (scan_addr),
        .scan_data    (scan_data),
        .scan_capture (scan_capture),
        .dmireset     (dmireset),
        .dmihardreset (dmihardreset),
        .cap_addr     (cap_addr),
        .cap_data     (cap_data),
        .cap_op       (cap_op),
        .dmistat      (dmistat),
        .busy         (busy),
        .dmi          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [31:0]      data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    int          n_hs    = 0;
    logic [31:0] model_cap = '0;

    always @(posedge clk) begin
        if (bus.req_valid && bus.req_ready) n_hs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input logic [1:0] op, input logic [ABITS-1:0] addr, input logic [31:0] d);
        scan_update = 1'b1;
        scan_op     = op;
        scan_addr   = addr;
        scan_data   = d;
        tick();
        scan_update = 1'b0;
    endtask

    task automatic pulse_dmireset();
        dmireset = 1'b1;
        tick();
        dmireset = 1'b0;
    endtask

    task automatic accept_req(input string tag);
        bit done = 1'b0;
        bus.req_ready = 1'b1;
        for (int i = 0; i < 32 && !done; i++) begin
            if (bus.req_valid) done = 1'b1;
            tick();
        end
        bus.req_ready = 1'b0;
        check({tag, ".req_hs"}, 32'(done), 32'd1);
    endtask

    task automatic respond(input string tag, input logic [31:0] d, input logic [1:0] op,
                           input int delay);
        bit done = 1'b0;
        repeat (delay) tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = d;
        bus.rsp_op    = op;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus.rsp_ready) done = 1'b1;
            tick();
        end
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_op    = '0;
        check({tag, ".rsp_hs"}, 32'(done), 32'd1);
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".cap_data"}, cap_data, e.data);
        check({tag, ".cap_addr"}, 32'(cap_addr), 32'(e.addr));
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [ABITS-1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic [1:0] rop, input int delay);
        exp_t e;
        e.addr = addr;
        e.data = rdata;
        sb_q.push_back(e);
        scan(op, addr, wdata);
        check({tag, ".req_valid"}, 32'(bus.req_valid), 32'd1);
        check({tag, ".req_addr"}, 32'(bus.req_addr), 32'(addr));
        check({tag, ".req_op"}, 32'(bus.req_op), 32'(op));
        check({tag, ".req_data"}, bus.req_data, wdata);
        check({tag, ".cap_op_busy"}, 32'(cap_op), 32'd3);
        accept_req(tag);
        check({tag, ".rsp_ready"}, 32'(bus.rsp_ready), 32'd1);
        respond(tag, rdata, rop, delay);
        pop_and_check(tag);
        model_cap = rdata;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        scan_update = 1'b0; scan_capture = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
        scan_op = '0; scan_addr = '0; scan_data = '0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_op = '0;
        #12;
        check("rst.req_valid", 32'(bus.req_valid), 32'd0);
        check("rst.rsp_ready", 32'(bus.rsp_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.dmistat", 32'(dmistat), 32'd0);
        check("rst.cap_op", 32'(cap_op), 32'd0);
        check("rst.cap_data", cap_data, 32'd0);
        check("rst.cap_addr", 32'(cap_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Read with a 5-cycle DM latency.
        run_txn("read", 2'd1, 7'h11, 32'h0, 32'hDEADBEEF, 2'd0, 5);
        check("read.cap_op", 32'(cap_op), 32'd0);
        check("read.dmistat", 32'(dmistat), 32'd0);
        check("read.n_hs", 32'(n_hs), 32'd1);

        // NOP and reserved ops are ignored in IDLE.
        scan(2'd0, 7'h01, 32'h0);
        check("nop.busy", 32'(busy), 32'd0);
        scan(2'd3, 7'h02, 32'h0);
        check("rsvd.busy", 32'(busy), 32'd0);
        check("rsvd.cap_addr", 32'(cap_addr), 32'h11);

        // Second update while the DM stalls the request.
        scan(2'd2, 7'h22, 32'hA5A50000);
        check("busy.req_valid", 32'(bus.req_valid), 32'd1);
        tick();
        tick();
        scan(2'd2, 7'h33, 32'h0000FFFF);
        check("busy.dmistat", 32'(dmistat), 32'd3);
        check("busy.req_addr_held", 32'(bus.req_addr), 32'h22);
        check("busy.req_data_held", bus.req_data, 32'hA5A50000);
        e.addr = 7'h22; e.data = 32'hCAFE0001;
        sb_q.push_back(e);
        accept_req("busy");
        respond("busy", 32'hCAFE0001, 2'd0, 1);
        pop_and_check("busy");
        model_cap = 32'hCAFE0001;
        check("busy.n_hs", 32'(n_hs), 32'd2);
        check("busy.dmistat_sticky", 32'(dmistat), 32'd3);
        check("busy.cap_op", 32'(cap_op), 32'd3);
        scan(2'd1, 7'h44, 32'h0);
        check("busy.ignored_valid", 32'(bus.req_valid), 32'd0);
        check("busy.ignored_busy", 32'(busy), 32'd0);
        check("busy.ignored_addr", 32'(cap_addr), 32'h22);
        pulse_dmireset();
        check("busy.cleared", 32'(dmistat), 32'd0);
        run_txn("read44", 2'd1, 7'h44, 32'h0, 32'h44444444, 2'd0, 0);
        check("read44.n_hs", 32'(n_hs), 32'd3);

        // Timeout after 16 RSP cycles, then the late response is swallowed in DRAIN.
        e.addr = 7'h55; e.data = model_cap;
        sb_q.push_back(e);
        scan(2'd1, 7'h55, 32'h0);
        accept_req("tmo");
        repeat (TIMEOUT - 1) tick();
        check("tmo.before_stat", 32'(dmistat), 32'd0);
        check("tmo.before_rdy", 32'(bus.rsp_ready), 32'd1);
        tick();
        check("tmo.stat", 32'(dmistat), 32'd2);
        check("tmo.busy", 32'(busy), 32'd1);
        check("tmo.cap_op", 32'(cap_op), 32'd3);
        check("tmo.drain_rdy", 32'(bus.rsp_ready), 32'd1);
        respond("tmo", 32'h00001234, 2'd0, 3);
        pop_and_check("tmo");
        check("tmo.stat_kept", 32'(dmistat), 32'd2);
        check("tmo.cap_op_idle", 32'(cap_op), 32'd2);
        pulse_dmireset();

        // Response in the TIMEOUT-th cycle beats the timeout.
        run_txn("edge", 2'd1, 7'h56, 32'h0, 32'h0BADF00D, 2'd0, TIMEOUT - 1);
        check("edge.dmistat", 32'(dmistat), 32'd0);

        // DM error responses.
        run_txn("dmerr1", 2'd2, 7'h10, 32'h12345678, 32'h00001111, 2'd3, 2);
        check("dmerr1.dmistat", 32'(dmistat), 32'd3);
        pulse_dmireset();
        check("dmerr.cleared", 32'(dmistat), 32'd0);
        run_txn("dmerr2", 2'd1, 7'h12, 32'h0, 32'h00002222, 2'd2, 0);
        check("dmerr2.dmistat", 32'(dmistat), 32'd2);
        pulse_dmireset();

        // Hard reset while waiting for a response.
        e.addr = 7'h20; e.data = model_cap;
        sb_q.push_back(e);
        scan(2'd1, 7'h20, 32'h0);
        accept_req("hrst");
        tick();
        scan_capture = 1'b1;
        tick();
        scan_capture = 1'b0;
        check("hrst.capture_busy", 32'(dmistat), 32'd3);
        dmihardreset = 1'b1;
        tick();
        dmihardreset = 1'b0;
        check("hrst.dmistat", 32'(dmistat), 32'd0);
        check("hrst.rsp_ready", 32'(bus.rsp_ready), 32'd1);
        check("hrst.busy", 32'(busy), 32'd1);
        respond("hrst", 32'h00007777, 2'd0, 2);
        pop_and_check("hrst");
        check("hrst.dmistat_after", 32'(dmistat), 32'd0);
        run_txn("hrst_read", 2'd1, 7'h66, 32'h0, 32'h600D600D, 2'd0, 1);

        // Hard reset while the request is still pending.
        scan(2'd2, 7'h30, 32'h5);
        check("hreq.req_valid", 32'(bus.req_valid), 32'd1);
        dmihardreset = 1'b1;
        tick();
        dmihardreset = 1'b0;
        check("hreq.dropped", 32'(bus.req_valid), 32'd0);
        check("hreq.busy", 32'(busy), 32'd0);
        check("hreq.n_hs", 32'(n_hs), 32'd9);

        // Asynchronous reset mid-request.
        scan(2'd1, 7'h31, 32'h0);
        check("arst.pre_valid", 32'(bus.req_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.req_valid", 32'(bus.req_valid), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.cap_addr", 32'(cap_addr), 32'd0);
        check("arst.cap_data", cap_data, 32'd0);
        check("arst.req_addr", 32'(bus.req_addr), 32'd0);
        check("arst.cap_op", 32'(cap_op), 32'd0);
        #2;
        rst = 1'b0;
        model_cap = '0;
        tick();
        run_txn("post_rst", 2'd1, 7'h77, 32'h0, 32'h77777777, 2'd0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dtm_dmi_master.md
# dtm_dmi_master

Single-clock DMI transaction engine between the JTAG DTM scan logic and the Debug Module, parametrised in address width and response timeout. Takes already-synchronised DR-update/capture events for the DMI register, issues one DMI request at a time over a valid/ready bus, and collects the response. Maintains the sticky `dmistat` error state and supports `dmireset` and `dmihardreset`, including safe abort of an in-flight transaction.

## Interface
Parameters:
- `ABITS`, 7: DMI address width, 1..32.
- `TIMEOUT`, 1024: cycles waited for a response before failing; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; everything is sampled on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `scan_update`  in  1  one-cycle pulse: Update-DR with IR=DMI.
- `scan_op`  in  2  op field of the scanned DMI value.
- `scan_addr`  in  ABITS  address field of the scanned DMI value.
- `scan_data`  in  32  data field of the scanned DMI value.
- `scan_capture`  in  1  one-cycle pulse: Capture-DR with IR=DMI.
- `dmireset`  in  1  one-cycle pulse: clear sticky status.
- `dmihardreset`  in  1  one-cycle pulse: clear status and abort the transaction.
- `cap_addr`  out  ABITS  address of the last launched request.
- `cap_data`  out  32  data of the last completed response.
- `cap_op`  out  2  status value loaded into the DR on capture.
- `dmistat`  out  2  sticky status: 0 NOERROR, 2 FAILED, 3 BUSY.
- `busy`  out  1  high in any state except IDLE.
- `req_valid`  out  1  request valid.
- `req_ready`  in  1  DM accepts request.
- `req_addr`  out  ABITS  request address.
- `req_data`  out  32  request write data.
- `req_op`  out  2  1 read, 2 write.
- `rsp_valid`  in  1  DM response valid.
- `rsp_ready`  out  1  high in RSP and DRAIN.
- `rsp_data`  in  32  response data.
- `rsp_op`  in  2  0 ok, 2 failed, 3 busy.

## Operation
- **States:** IDLE, REQ, RSP, DRAIN.
- **IDLE → REQ:** on `scan_update` with op 1 or 2, when `dmistat`==0. Latch addr/data/op into the `req_*` registers and `cap_addr`.
- **Ignored updates, IDLE:**
  - op 0 or op 3: no transaction, no status change.
  - `dmistat`!=0: no transaction, no status change.
- **Update while busy:** `scan_update` with op 1/2 while not IDLE: request dropped; `dmistat`←3 if it was 0.
- **Capture while busy:** `scan_capture` while not IDLE and `dmistat`==0: `dmistat`←3.
- **`cap_op`:** 3 while `busy`, else `dmistat`.
- **REQ:** `req_valid`=1 and `req_*` held stable until `req_valid & req_ready`, then → RSP. No timeout in REQ.
- **RSP, response handshake:** on `rsp_valid`: `cap_data`←`rsp_data`; if `rsp_op`!=0 and `dmistat`==0, `dmistat`←`rsp_op` (op 1 is treated as 2). Then → IDLE.
- **RSP, timeout:** response counter reaches TIMEOUT → `dmistat`←2 if it was 0, → DRAIN.
- **DRAIN:** swallows one `rsp_valid` without updating `cap_data`/`dmistat`, or waits a further TIMEOUT cycles, then → IDLE. With TIMEOUT=0, DRAIN waits only for `rsp_valid`.
- **`dmihardreset`:**
  - `dmistat`←0.
  - REQ → IDLE, with `req_valid` dropped in the next cycle.
  - RSP → DRAIN.
  - IDLE/DRAIN unchanged.
- **`dmireset`:** `dmistat`←0. Priority over any error set in the same cycle.
- **Status priority:** hardreset/dmireset > response/timeout error > busy error.

## Timing
- **Reset values:**
  - state IDLE; counter 0.
  - `req_valid`, `rsp_ready`, `busy` = 0.
  - `req_*`, `cap_addr`, `cap_data` = 0.
  - `dmistat`, `cap_op` = 0.
- **Request launch:** `scan_update` at cycle N → `req_valid`, `busy` high at N+1.
- **Request handshake:** at M → `rsp_ready` high at M+1.
- **Response handshake:** at K → `cap_data` updated and `busy` low at K+1. A `scan_update` in cycle K is a busy error.
- **Counter:** cleared on entry to RSP and to DRAIN. Timeout fires when `rsp_valid` is still absent after exactly TIMEOUT cycles in RSP. `rsp_valid` in the TIMEOUT-th cycle wins over the timeout.
- **All outputs are registered**, except `cap_op`, which is a decode of registered state.
- **Mid-operation reset:** `rst` asynchronously forces all reset values.

## Structure
- Package `dmi_pkg`:
  - `dmi_op_e` (NOP/READ/WRITE/RSVD).
  - `dmistat_e` (NOERROR/RESERVED/FAILED/BUSY).
  - `dmi_fsm_e`.
  - Shared with the DTM scan block.
- Sub-module `dmi_timeout_cnt`: clear/enable/expire counter; width `$clog2(TIMEOUT+1)`, minimum 1.

## Test plan
- **Read:** update op=1, addr=0x11. DM responds `rsp_op`=0, data 0xDEADBEEF after 5 cycles → `cap_data`=0xDEADBEEF, `cap_op`=0, `cap_addr`=0x11.
- **Busy:** update op=2 while `req_ready` held 0, then a second update op=2 → single request issued; `dmistat`=3; a later update op=1 is ignored until `dmireset`.
- **Timeout:** TIMEOUT=16, no response → `dmistat`=2 at cycle 16 of RSP, state DRAIN. A late `rsp_valid` data 0x1234 is swallowed; `cap_data` unchanged; `busy` drops next cycle.
- **DM error:** `rsp_op`=3, then a second transaction after `dmireset` with `rsp_op`=2 → `dmistat` 3, then 0, then 2.
- **Hard reset in RSP:** → `dmistat`=0, DRAIN, `rsp_ready`=1. Response consumed → IDLE; a new read then completes normally.
- **Async `rst` asserted during REQ:** `req_valid`=0 immediately; all outputs at reset values.
